axi_lite_master: RTL
====================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, AXI address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, AXI data width in bits; WSTRB width is DATA_WIDTH/8.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset, with ports ACLK and ARESETn as below.
REQ-004 ACLK  input  1  clock, all state updates on rising edge.
REQ-005 ARESETn  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_WIDTH  transaction address.
REQ-010 cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 cmd_wstrb  input  DATA_WIDTH/8  write byte strobes.
REQ-012 rsp_valid  output  1  one-cycle completion pulse.
REQ-013 rsp_write  output  1  type of completed transaction.
REQ-014 rsp_rdata  output  DATA_WIDTH  read data; held until the next read completes.
REQ-015 AWADDR/AWVALID out, AWREADY in; WDATA/WSTRB/WVALID out, WREADY in; BVALID in, BREADY out; ARADDR/ARVALID out, ARREADY in; RDATA/RVALID in, RREADY out.

Function
REQ-016 FSM states: IDLE, WRITE, WRESP, RADDR, RDATA; cmd_ready SHALL be 1 only in IDLE.
REQ-017 On a write command accepted in IDLE, the next cycle SHALL enter WRITE with AWVALID=1, WVALID=1, and AWADDR/WDATA/WSTRB registered from the command.
REQ-018 In WRITE, AWVALID SHALL drop the cycle after AWVALID && AWREADY, and WVALID SHALL drop the cycle after WVALID && WREADY; each channel is tracked by its own done flag.
REQ-019 If both handshakes occur in the same cycle, both VALIDs SHALL drop together; the FSM SHALL enter WRESP the cycle after both done flags are set, or the same edge as the last handshake.
REQ-020 In WRESP, BREADY SHALL be 1; on BVALID && BREADY, the FSM SHALL pulse rsp_valid=1 and rsp_write=1 for one cycle and return to IDLE.
REQ-021 On a read command accepted, the next cycle SHALL enter RADDR with ARVALID=1 and ARADDR registered from the command.
REQ-022 After ARVALID && ARREADY, ARVALID SHALL drop and the FSM SHALL enter RDATA with RREADY=1.
REQ-023 In RDATA, on RVALID && RREADY, the block SHALL capture RDATA into rsp_rdata, pulse rsp_valid with rsp_write=0, deassert RREADY, and return to IDLE.
REQ-024 Once asserted, a VALID SHALL not drop and its payload SHALL not change until that channel's handshake completes.
REQ-025 Only one transaction SHALL be outstanding; cmd inputs are ignored outside IDLE.
REQ-026 The block SHALL have no timeout; a non-responding slave holds the FSM indefinitely.
REQ-027 Minimum write latency: command accept to rsp_valid is 3 cycles against a zero-wait slave that responds with READY in the first VALID cycle.

Reset
REQ-028 On ARESETn low, the block SHALL immediately clear AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_write, rsp_rdata and both done flags, and set the FSM to IDLE.
REQ-029 In reset, cmd_ready SHALL be 0; it SHALL be 1 from the first clock after reset release.
REQ-030 Reset mid-transaction SHALL abandon the transaction without emitting rsp_valid.

Verification
REQ-031 Write addr 0x4, data 0xDEADBEEF, strb 0xF, slave READY on first VALID cycle -> AW/W handshakes occur in the same cycle, BREADY=1, one rsp_valid pulse with rsp_write=1.
REQ-032 Read addr 0x4 after REQ-031 against the team AXI4-Lite slave -> rsp_rdata=0xDEADBEEF, rsp_write=0, one rsp_valid pulse.
REQ-033 WREADY delayed 3 cycles after AWREADY -> AWVALID drops after its handshake, WVALID stays high with stable WDATA, WRESP is entered only after the W handshake.
REQ-034 Write strb 0x3, data 0x0000A5A5 to addr 0x8 preloaded with 0x12345678, then read addr 0x8 -> rsp_rdata=0x1234A5A5.
REQ-035 ARESETn low while in WRESP with BVALID withheld -> all VALID/READY outputs are 0 asynchronously, no rsp_valid, and cmd_ready=1 one cycle after release.
REQ-036 cmd_valid held high continuously with alternating write/read -> exactly one transaction outstanding, cmd_ready=0 outside IDLE, one rsp_valid per accepted command.

Source files
------------

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns single cmd_* requests into one AXI4-Lite write or
// read transaction and reports completion on rsp_*.
//
// Ports
//   ACLK, ARESETn        clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready is high only when idle
//   cmd_write            1 = write, 0 = read
//   cmd_addr/wdata/wstrb command payload, captured on acceptance
//   rsp_valid            one-cycle completion pulse
//   rsp_write            type of the completed transaction
//   rsp_rdata            last read data, held until the next read completes
//   AW*/W*/B*/AR*/R*     AXI4-Lite master channels
module axi_lite_master #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {StIdle, StWrite, StWresp, StRaddr, StRdata} state_e;

  state_e                  state_q, state_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  // Keeps cmd_ready low during reset and until the first clock after release.
  logic                    run_q;

  // All channel controls decode from registered state, so reset clears them at once.
  assign cmd_ready = run_q && (state_q == StIdle);
  assign AWVALID   = (state_q == StWrite) && !aw_done_q;
  assign WVALID    = (state_q == StWrite) && !w_done_q;
  assign BREADY    = (state_q == StWresp);
  assign ARVALID   = (state_q == StRaddr);
  assign RREADY    = (state_q == StRdata);
  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= StIdle;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      run_q       <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? StWrite : StRaddr;
        end
      end
      StWrite: begin
        aw_done_d = aw_done_q || (AWVALID && AWREADY);
        w_done_d  = w_done_q || (WVALID && WREADY);
        // Leave on the edge of the last handshake; flags are cleared for the next write.
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWresp;
        end
      end
      StWresp: begin
        if (BVALID) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StRaddr: begin
        if (ARREADY) begin
          state_d = StRdata;
        end
      end
      StRdata: begin
        if (RVALID) begin
          rsp_rdata_d = RDATA;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
